// File: rtl/dtls_rx_arb_64.sv
// Frame-level round-robin arbiter: merges PORTS 64-bit UDP payload streams into one
// registered output stream toward the DTLS parser, tagging the source and truncating long frames.
module dtls_rx_arb_64 #(
  parameter int PORTS     = 4,
  parameter int ID_WIDTH  = 2,
  parameter int MAX_BEATS = 190
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORTS*64-1:0]   s_axis_tdata,
  input  logic [PORTS*8-1:0]    s_axis_tkeep,
  input  logic [PORTS-1:0]      s_axis_tvalid,
  output logic [PORTS-1:0]      s_axis_tready,
  input  logic [PORTS-1:0]      s_axis_tlast,
  input  logic [PORTS-1:0]      s_axis_tuser,
  input  logic [PORTS-1:0]      port_enable,
  output logic [63:0]           m_axis_tdata,
  output logic [7:0]            m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic                  busy,
  output logic                  error_oversize
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam logic [15:0] LP_LAST_CNT = 16'(MAX_BEATS - 1);

  state_t               r_state;
  logic [ID_WIDTH-1:0]  r_grant;
  logic [ID_WIDTH-1:0]  r_last;
  logic [15:0]          r_cnt;

  logic [PORTS-1:0]     w_req;
  logic                 w_found;
  logic [ID_WIDTH-1:0]  w_next;
  int                   w_dist;
  int                   w_best;
  logic [63:0]          w_data;
  logic [7:0]           w_keep;
  logic                 w_tlast;
  logic                 w_tuser;
  logic                 w_out_free;
  logic                 w_acc;
  logic                 w_trunc;

  assign w_req      = s_axis_tvalid & port_enable;
  assign w_found    = |w_req;
  assign w_out_free = !m_axis_tvalid || m_axis_tready;
  // Only the granted port can ever see ready, so any handshake is the granted one.
  assign w_acc      = |(s_axis_tvalid & s_axis_tready);
  assign w_trunc    = (r_state == ST_XFER) && w_acc && !w_tlast && (r_cnt == LP_LAST_CNT);

  // Round-robin pick: requester with the smallest circular distance after r_last.
  always_comb begin
    w_next = r_last;
    w_best = PORTS;
    w_dist = 0;
    for (int i = 0; i < PORTS; i++) begin
      w_dist = (i + PORTS - 1 - int'(r_last)) % PORTS;
      if (w_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_next = ID_WIDTH'(i);
      end else begin
        w_best = w_best;
      end
    end
  end

  // Mux the granted port's beat fields.
  always_comb begin
    w_data  = 64'd0;
    w_keep  = 8'd0;
    w_tlast = 1'b0;
    w_tuser = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (r_grant == ID_WIDTH'(i)) begin
        w_data  = s_axis_tdata[i*64 +: 64];
        w_keep  = s_axis_tkeep[i*8 +: 8];
        w_tlast = s_axis_tlast[i];
        w_tuser = s_axis_tuser[i];
      end else begin
        w_data  = w_data;
      end
    end
  end

  // Per-port ready: follows output-register space in XFER, always open in DROP.
  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (r_grant == ID_WIDTH'(i)) begin
        case (r_state)
          ST_XFER: s_axis_tready[i] = w_out_free;
          ST_DROP: s_axis_tready[i] = 1'b1;
          default: s_axis_tready[i] = 1'b0;
        endcase
      end else begin
        s_axis_tready[i] = 1'b0;
      end
    end
  end

  // Arbitration FSM together with the output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_grant        <= '0;
      r_last         <= ID_WIDTH'(PORTS - 1);
      r_cnt          <= 16'd0;
      m_axis_tdata   <= 64'd0;
      m_axis_tkeep   <= 8'd0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axis_tuser   <= 1'b0;
      m_axis_tid     <= '0;
      busy           <= 1'b0;
      error_oversize <= 1'b0;
    end else begin
      error_oversize <= 1'b0;
      if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_next;
            r_cnt   <= 16'd0;
            r_state <= ST_XFER;
            busy    <= 1'b1;
          end
        end
        ST_XFER: begin
          if (w_acc) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= w_data;
            m_axis_tkeep  <= w_keep;
            m_axis_tlast  <= w_tlast || w_trunc;
            m_axis_tuser  <= w_tuser || w_trunc;
            m_axis_tid    <= r_grant;
            r_cnt         <= r_cnt + 16'd1;
            if (w_tlast) begin
              r_last  <= r_grant;
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end else if (w_trunc) begin
              error_oversize <= 1'b1;
              r_state        <= ST_DROP;
            end
          end
        end
        ST_DROP: begin
          if (w_acc && w_tlast) begin
            r_last  <= r_grant;
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtls_rx_arb_64.sv
// Randomized bench for dtls_rx_arb_64: per-port frame queues feed the DUT and a
// queue-based frame-level model predicts the output beat sequence and truncations.
module tb_dtls_rx_arb_64;
  localparam int P   = 4;
  localparam int IDW = 2;
  localparam int MB  = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct packed {
    logic [IDW-1:0] tid;
    beat_t          b;
  } obeat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [P*64-1:0]   s_tdata;
  logic [P*8-1:0]    s_tkeep;
  logic [P-1:0]      s_tvalid, s_tready, s_tlast, s_tuser, port_enable;
  logic [63:0]       m_tdata;
  logic [7:0]        m_tkeep;
  logic              m_tvalid, m_tready, m_tlast, m_tuser;
  logic [IDW-1:0]    m_tid;
  logic              busy, error_oversize;

  always #5 clk = ~clk;

  dtls_rx_arb_64 #(.PORTS(P), .ID_WIDTH(IDW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .port_enable(port_enable),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .m_axis_tid(m_tid), .busy(busy), .error_oversize(error_oversize)
  );

  beat_t     src_q[P][$];
  obeat_t    exp_q[$];
  int        n_checks = 0;
  int        n_errors = 0;
  int        obs_n, exp_n, ovs_seen, ovs_exp;
  int        model_last = P - 1;
  logic [P-1:0] model_mask;
  int        bp_mode = 0;
  int        bp_idx = 0;

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < P; p++) begin
      if (src_q[p].size() > 0) begin
        s_tvalid[p]          = 1'b1;
        s_tdata[p*64 +: 64]  = src_q[p][0].data;
        s_tkeep[p*8 +: 8]    = src_q[p][0].keep;
        s_tlast[p]           = src_q[p][0].last;
        s_tuser[p]           = src_q[p][0].user;
      end else begin
        s_tvalid[p]          = 1'b0;
        s_tdata[p*64 +: 64]  = 64'd0;
        s_tkeep[p*8 +: 8]    = 8'd0;
        s_tlast[p]           = 1'b0;
        s_tuser[p]           = 1'b0;
      end
    end
    case (bp_mode)
      1:       m_tready = 1'($urandom_range(0, 1));
      2:       m_tready = ((bp_idx % 3) == 0);
      default: m_tready = 1'b1;
    endcase
    bp_idx++;
  endtask

  // One clock: observe handshakes at the falling edge, update stimulus just after the rising edge.
  task automatic cycle();
    logic [P-1:0] acc;
    obeat_t ob, ex;
    @(negedge clk);
    acc = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      obs_n++;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        ob.tid = m_tid;
        ob.b   = '{data: m_tdata, keep: m_tkeep, last: m_tlast, user: m_tuser};
        check_eq("out_beat", 96'(ob), 96'(ex));
      end
    end
    if (error_oversize) ovs_seen++;
    @(posedge clk);
    #1;
    for (int p = 0; p < P; p++) begin
      if (acc[p]) void'(src_q[p].pop_front());
    end
    drive_inputs();
  endtask

  task automatic add_frame(input int p, input int len, input bit seq);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = seq ? 64'(i + 1) : {$urandom, $urandom};
      b.keep = seq ? 8'hFF : 8'($urandom);
      b.user = seq ? 1'b0 : ($urandom_range(0, 7) == 0);
      b.last = (i == len - 1);
      src_q[p].push_back(b);
    end
  endtask

  // Reference: rotate a pointer over eligible ports with frames, forward whole frames capped at MB beats.
  task automatic build_expected(input logic [P-1:0] mask);
    beat_t cp[P][$];
    beat_t fr[$];
    beat_t b;
    obeat_t ob;
    int pick, n;
    exp_q.delete();
    obs_n = 0; exp_n = 0; ovs_seen = 0; ovs_exp = 0;
    model_mask = mask;
    for (int p = 0; p < P; p++) cp[p] = src_q[p];
    forever begin
      pick = -1;
      for (int k = 1; k <= P; k++) begin
        if (pick < 0 && mask[(model_last + k) % P] && cp[(model_last + k) % P].size() > 0)
          pick = (model_last + k) % P;
      end
      if (pick < 0) break;
      fr.delete();
      do begin
        b = cp[pick].pop_front();
        fr.push_back(b);
      end while (!b.last);
      n = (fr.size() > MB) ? MB : fr.size();
      for (int i = 0; i < n; i++) begin
        ob.tid = IDW'(pick);
        ob.b   = fr[i];
        if (fr.size() > MB && i == MB - 1) begin
          ob.b.last = 1'b1;
          ob.b.user = 1'b1;
        end
        exp_q.push_back(ob);
        exp_n++;
      end
      if (fr.size() > MB) ovs_exp++;
      model_last = pick;
    end
    drive_inputs();
  endtask

  function automatic bit pending();
    bit r = 1'b0;
    for (int p = 0; p < P; p++) if (model_mask[p] && src_q[p].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic run_phase(input string tag);
    int c = 0;
    while ((exp_q.size() > 0 || pending() || busy) && c < 3000) begin
      cycle();
      c++;
    end
    check_eq({tag, "_drained"}, 96'(c < 3000), 96'd1);
    cycle();
    cycle();
    check_eq({tag, "_beats"}, 96'(obs_n), 96'(exp_n));
    check_eq({tag, "_oversize"}, 96'(ovs_seen), 96'(ovs_exp));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_m_ctrl"}, {m_tvalid, m_tlast, m_tuser, m_tid, busy, error_oversize}, 96'd0);
    check_eq({tag, "_m_data"}, {m_tdata, m_tkeep, s_tready}, 96'd0);
  endtask

  initial begin
    int n1, c, mask;
    port_enable = 4'hF;
    drive_inputs();
    #1 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    cycle();
    cycle();
    #2 rst_n = 1'b1;

    // grant latency and single-beat frame
    add_frame(0, 1, 1'b0);
    build_expected(4'hF);
    cycle();
    check_eq("latency_n1_valid", 96'(m_tvalid), 96'd0);
    cycle();
    check_eq("latency_n2_valid", 96'(m_tvalid), 96'd1);
    check_eq("single_beat_tlast", 96'(m_tlast), 96'd1);
    run_phase("single");

    // fairness: all ports, continuous 3-beat frames
    for (int f = 0; f < 3; f++) for (int p = 0; p < P; p++) add_frame(p, 3, 1'b0);
    build_expected(4'hF);
    run_phase("fair");

    // back-pressure: port 2, data 1..5, ready pattern 1,0,0
    bp_mode = 2;
    add_frame(2, 5, 1'b1);
    build_expected(4'hF);
    run_phase("backpressure");
    bp_mode = 0;

    // oversize: 7 beats on port 1
    add_frame(1, 7, 1'b0);
    build_expected(4'hF);
    run_phase("oversize");
    check_eq("oversize_src_consumed", 96'(src_q[1].size()), 96'd0);

    // boundary: exactly MB beats, then a single-beat frame
    add_frame(3, MB, 1'b1);
    add_frame(0, 1, 1'b1);
    build_expected(4'hF);
    run_phase("boundary");

    // enable gating: port 1 requests but is never eligible
    bp_mode = 1;
    port_enable = 4'b1101;
    for (int p = 0; p < P; p++) begin
      add_frame(p, $urandom_range(1, 6), 1'b0);
      add_frame(p, $urandom_range(1, 6), 1'b0);
    end
    n1 = src_q[1].size();
    build_expected(4'b1101);
    run_phase("gating");
    check_eq("gating_port1_untouched", 96'(src_q[1].size()), 96'(n1));
    src_q[1].delete();
    port_enable = 4'hF;
    drive_inputs();

    // clearing enable of the granted port mid-frame lets the frame finish
    add_frame(0, 3, 1'b0);
    build_expected(4'hF);
    c = 0;
    while (!m_tvalid && c < 20) begin
      cycle();
      c++;
    end
    port_enable[0] = 1'b0;
    run_phase("enable_midframe");
    port_enable = 4'hF;

    // randomized rounds with random enable masks
    for (int r = 0; r < 20; r++) begin
      mask = $urandom_range(1, 15);
      port_enable = 4'(mask);
      for (int p = 0; p < P; p++) begin
        int nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) add_frame(p, $urandom_range(1, 7), 1'b0);
      end
      build_expected(4'(mask));
      run_phase("random");
      for (int p = 0; p < P; p++) if (!mask[p]) src_q[p].delete();
      port_enable = 4'hF;
      drive_inputs();
    end

    // asynchronous reset in the middle of traffic
    for (int p = 0; p < P; p++) add_frame(p, 6, 1'b0);
    build_expected(4'hF);
    for (int i = 0; i < 6; i++) cycle();
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midframe_reset");
    for (int p = 0; p < P; p++) src_q[p].delete();
    exp_q.delete();
    model_last = P - 1;
    bp_mode = 0;
    drive_inputs();
    cycle();
    cycle();
    #2 rst_n = 1'b1;
    for (int p = 0; p < P; p++) add_frame(p, 1, 1'b0);
    build_expected(4'hF);
    cycle();
    cycle();
    check_eq("post_reset_valid", 96'(m_tvalid), 96'd1);
    check_eq("post_reset_first_tid", 96'(m_tid), 96'd0);
    run_phase("post_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dtls_rx_arb_64.md
# dtls_rx_arb_64

Frame-level round-robin arbiter that shares one 64-bit DTLS receive parser among several UDP payload AXI streams. Each input frame is granted whole, from first beat to `tlast`, and forwarded through a registered output stage. The output is tagged with its source port, and frames longer than `MAX_BEATS` are truncated. The block sits directly upstream of the DTLS UDP receive path, with one input per UDP socket or queue.

## Interface
- `PORTS`, 4: number of input streams, 2..8.
- `ID_WIDTH`, 2: width of the port index; must be at least ceil(log2(PORTS)).
- `MAX_BEATS`, 190: maximum number of beats forwarded per frame, 1..65535.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous reset, active low.
- `s_axis_tdata` in PORTS*64: input data; port i occupies bits [64i+63:64i].
- `s_axis_tkeep` in PORTS*8: input byte enables.
- `s_axis_tvalid` in PORTS: per-port valid.
- `s_axis_tready` out PORTS: per-port ready.
- `s_axis_tlast` in PORTS: per-port end of frame.
- `s_axis_tuser` in PORTS: per-port error flag.
- `port_enable` in PORTS: a port is eligible for a new grant only while its bit is 1.
- `m_axis_tdata` out 64, `m_axis_tkeep` out 8, `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tlast` out 1, `m_axis_tuser` out 1: output stream toward the DTLS parser.
- `m_axis_tid` out ID_WIDTH: source port of the current output beat.
- `busy` out 1: high while in XFER or DROP.
- `error_oversize` out 1: one-cycle pulse when a frame is truncated.

## Operation
- The FSM has three states: IDLE, XFER and DROP. There is one grant register (`grant`) and one last-grant pointer (`last`), which resets to PORTS-1.
- **IDLE:**
  - The requesters are the ports with `s_axis_tvalid & port_enable`.
  - If any requester exists, grant the first one found scanning `last+1`, `last+2`, … with wrap modulo PORTS.
  - Then clear the beat counter and go to XFER.
  - All `s_axis_tready` bits are 0 in IDLE.
- **XFER:**
  - `s_axis_tready[grant] = !m_axis_tvalid | m_axis_tready`; all other ready bits are 0.
  - An accepted beat loads the output register. `tid` is set to `grant`, and the beat counter increments (16-bit counter).
  - On an accepted beat with `tlast`, set `last <= grant` and go to IDLE.
  - On an accepted beat that is the MAX_BEATS-th beat and has `tlast` = 0:
    - Forward it with `m_axis_tlast` = 1 and `m_axis_tuser` = 1.
    - Pulse `error_oversize`.
    - Go to DROP.
  - A beat whose input `tuser` is 1 passes through unchanged.
- **DROP:**
  - `s_axis_tready[grant]` = 1, and incoming beats are discarded.
  - On an accepted beat with `tlast`, set `last <= grant` and go to IDLE.
- **`port_enable` changes:** deasserting the granted port's enable mid-frame has no effect; the frame completes. It only affects eligibility in IDLE.
- **Output register:** holds its contents while `m_axis_tvalid & !m_axis_tready`, and clears valid when it is accepted with no new load.

## Timing
- **Reset values** (`rst_n` = 0, asynchronous): `m_axis_tvalid`/`tlast`/`tuser` = 0, `tdata`/`tkeep`/`tid` = 0, `s_axis_tready` = 0, `busy` = 0, `error_oversize` = 0, FSM = IDLE, `grant` = 0, `last` = PORTS-1, counter = 0. Reset mid-frame abandons the frame with no flush.
- **Grant latency:** a request is sampled in IDLE at cycle N; ready is high at N+1; the first output beat is valid at N+2.
- **Throughput:** one beat per cycle while `m_axis_tready` = 1. There is exactly one idle input cycle between consecutive frames (the IDLE state).
- **Back-pressure:** ready to the granted port drops combinationally when the output register is full and `m_axis_tready` = 0. The output never drops or duplicates a beat.
- **Simultaneous requests:** round-robin priority applies, and a port granted last has the lowest priority next time.
- **Single-beat frame** (`tlast` on the first beat): XFER lasts one accepted beat, then the FSM returns to IDLE.
- **Frame length limits:**
  - Exactly MAX_BEATS beats with `tlast` on the last one: normal completion, no error.
  - MAX_BEATS+1 or more beats: truncation as described under Operation.
- **`error_oversize`:** asserts in the cycle after the truncating beat is accepted, for one cycle.

## Test plan
- **Reset:** assert `rst_n` = 0 asynchronously mid-frame. Required: all outputs at their reset values immediately, and after release port 0 is granted first when all ports request.
- **Fairness:** all 4 ports enabled, each sending 3-beat frames continuously. Required: `m_axis_tid` sequence 0,1,2,3,0,1… with no starvation.
- **Back-pressure:** port 2 sends 5 beats with data 0x0000_0000_0000_0001..5 while `m_axis_tready` toggles 1,0,0,1,…. Required: exactly 5 beats in order, `tlast` on beat 5, `tid` = 2 throughout.
- **Oversize:** MAX_BEATS = 4, port 1 sends 7 beats. Required:
  - 4 beats out, the 4th with `tlast` = 1 and `tuser` = 1.
  - `error_oversize` pulses once.
  - Beats 5–7 are consumed with `s_axis_tready[1]` = 1 and none appear on the output.
- **Enable gating:** `port_enable` = 4'b1101 with all ports requesting. Required: port 1 is never granted. Clearing bit 0 during a port-0 frame still completes that frame.
- **Boundary:** MAX_BEATS = 4 and a 4-beat frame with `tlast` on beat 4. Required: no `tuser`, no `error_oversize`. A 1-beat frame is forwarded with `tlast` = 1.
